move_controller: RTL
====================

Name: move_controller

Overview:
- Upstream stage of the win detector; owns the board state.
- Debounces the Basys3 "place" push-button and validates the selected cell.
- Writes the current player's mark into pos1..pos9 and alternates turns.
- Freezes the board while the win detector reports a win or tie. The detector's reset output, ORed with the system reset, drives this block's reset to start a new game.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a button level (10 ms at 100 MHz).
- FIRST_PLAYER, 2'b01, player who moves first after reset; legal values 2'b01 or 2'b10.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high; clears all state
- btn_place  input  1  raw push-button, asynchronous to clk
- btn_undo  input  1  raw push-button; used only with UNDO_EN, ignored otherwise
- sel  input  4  selected cell index; 1..9 valid, cell n maps to posn
- win  input  2  detector result: 00 playing, 01 P1 won, 10 P2 won, 11 tie
- pos1..pos9  output  2 each  cell contents: 00 empty, 01 player 1, 10 player 2
- turn  output  2  player to move next (01/10)
- move_count  output  4  accepted moves since reset, 0..9
- err  output  1  sticky illegal-move flag

Behaviour:
- Reset values (asynchronous, immediate):
  - pos1..pos9 = 00, turn = FIRST_PLAYER, move_count = 0, err = 0
  - FSM = IDLE; synchronizer flops, debounce counters and undo record cleared
- Input conditioning:
  - Each button passes through a 2-flop synchronizer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the current debounced level. Any sample equal to the current level restarts the count.
- FSM states: IDLE, EVAL, WAIT_RELEASE, LOCKED.
  - IDLE: win != 00 -> LOCKED. Debounced place rises -> EVAL.
  - EVAL: lasts exactly one cycle; sel and the cells are sampled in this cycle.
    - sel in 1..9 and target cell 00 -> cell := turn; turn flips (01<->10); move_count += 1; err := 0.
    - sel = 0, sel > 9, or cell occupied -> no board change; err := 1.
    - Then -> WAIT_RELEASE.
  - WAIT_RELEASE: debounced place low -> IDLE. win != 00 -> LOCKED (takes priority).
  - LOCKED: no writes; presses ignored; err unchanged. Exits only via reset.
- Latency: board update is visible on the clock edge ending EVAL. Counted from the first clk edge sampling btn_place high, that is 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- One move per press: holding the button cannot place twice; the button must be released (debounced) first.
- move_count never exceeds 9. At 9 every cell is occupied, so further presses flag err until the detector reports and locks the block.
- The win input is a registered output of the detector. A win arriving in the same cycle as EVAL does not cancel that EVAL's write; lock takes effect in the following state.
- Reset asserted mid-debounce or mid-EVAL aborts the operation; no partial write survives.
- sel is not debounced or registered beyond the EVAL sample; changes outside EVAL have no effect.

Optional Feature:
- Macro: MOVE_CONTROLLER_UNDO_EN.
- Defined:
  - btn_undo gets its own synchronizer and debouncer.
  - The block records the cell index of the last accepted move, plus a valid bit.
  - A debounced undo rising edge in IDLE with the record valid does all of the following in one cycle: clear that cell to 00, flip turn back, decrement move_count, clear err, invalidate the record.
  - Only one level of undo. Undo is ignored in LOCKED, in WAIT_RELEASE, or with no valid record.
- Not defined: btn_undo is unconnected internally; no undo logic or record is synthesized.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, sel=5, press btn_place for 10 cycles -> pos5=01 exactly 7 cycles after first high sample; turn=10; move_count=1; err=0; pos5 unchanged while held.
- Release, sel=5, press again -> pos5 stays 01, err=1, turn=10. Then sel=1, press -> pos1=10, err=0, move_count=2.
- btn_place glitch: high for 3 cycles, low for 1, high for 3 -> no move accepted, move_count unchanged.
- sel=0, then sel=12, each pressed -> err=1 both times, board all 00, turn=FIRST_PLAYER.
- Drive win=01 while in IDLE, then sel=9 and press -> pos9 stays 00, no err. Assert reset -> all cells 00, move_count=0, turn=01, and moves are accepted again.
- With MOVE_CONTROLLER_UNDO_EN: place at 3, then undo -> pos3=00, turn=01, move_count=0. Second undo -> no change.

Source files
------------

// File: rtl/move_controller.sv
// Tic-tac-toe move controller: debounces the place button, validates the selected cell,
// owns the board and alternates turns. Optional one-level undo via `MOVE_CONTROLLER_UNDO_EN`.
module move_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [1:0]  FIRST_PLAYER    = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_place,
    input  logic       btn_undo,
    input  logic [3:0] sel,
    input  logic [1:0] win,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic [3:0] move_count,
    output logic       err
);

    localparam int unsigned   DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned   CELL_W  = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EVAL         = 2'd1,
        WAIT_RELEASE = 2'd2,
        LOCKED       = 2'd3
    } state_t;

    state_t             state;
    logic [8:0][1:0]    board;

    // Place button: 2-flop synchronizer followed by a stable-sample debouncer
    logic               place_s1;
    logic               place_s2;
    logic               place_level;
    logic [DB_W-1:0]    place_cnt;
    logic               place_rise_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            place_s1    <= 1'b0;
            place_s2    <= 1'b0;
            place_level <= 1'b0;
            place_cnt   <= '0;
        end else begin
            place_s1 <= btn_place;
            place_s2 <= place_s1;
            if (place_s2 != place_level) begin
                if (place_cnt == DB_LAST) begin
                    place_level <= place_s2;
                    place_cnt   <= '0;
                end else begin
                    place_cnt <= place_cnt + DB_W'(1);
                end
            end else begin
                place_cnt <= '0;
            end
        end
    end

    // Rise is flagged on the cycle the debounced level is about to go high
    assign place_rise_c = place_s2 && !place_level && (place_cnt == DB_LAST);

`ifdef MOVE_CONTROLLER_UNDO_EN
    logic               undo_s1;
    logic               undo_s2;
    logic               undo_level;
    logic [DB_W-1:0]    undo_cnt;
    logic               undo_rise_c;
    logic [CELL_W-1:0]  rec_idx;
    logic               rec_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            undo_s1    <= 1'b0;
            undo_s2    <= 1'b0;
            undo_level <= 1'b0;
            undo_cnt   <= '0;
        end else begin
            undo_s1 <= btn_undo;
            undo_s2 <= undo_s1;
            if (undo_s2 != undo_level) begin
                if (undo_cnt == DB_LAST) begin
                    undo_level <= undo_s2;
                    undo_cnt   <= '0;
                end else begin
                    undo_cnt <= undo_cnt + DB_W'(1);
                end
            end else begin
                undo_cnt <= '0;
            end
        end
    end

    assign undo_rise_c = undo_s2 && !undo_level && (undo_cnt == DB_LAST);
`else
    logic unused_btn_undo;
    assign unused_btn_undo = btn_undo;
`endif

    // Target cell decode, sampled during EVAL
    logic               sel_ok_c;
    logic [CELL_W-1:0]  cell_idx_c;
    logic               cell_free_c;
    logic [1:0]         other_c;

    always_comb begin
        sel_ok_c    = (sel >= 4'd1) && (sel <= 4'd9);
        cell_idx_c  = CELL_W'(sel - 4'd1);
        cell_free_c = 1'b0;
        if (sel_ok_c) begin
            cell_free_c = (board[cell_idx_c] == 2'b00);
        end
        other_c = (turn == 2'b01) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            board      <= '0;
            turn       <= FIRST_PLAYER;
            move_count <= 4'd0;
            err        <= 1'b0;
`ifdef MOVE_CONTROLLER_UNDO_EN
            rec_idx    <= '0;
            rec_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win != 2'b00) begin
                        state <= LOCKED;
                    end else if (place_rise_c) begin
                        state <= EVAL;
                    end
`ifdef MOVE_CONTROLLER_UNDO_EN
                    else if (undo_rise_c && rec_valid) begin
                        board[rec_idx] <= 2'b00;
                        turn           <= other_c;
                        move_count     <= move_count - 4'd1;
                        err            <= 1'b0;
                        rec_valid      <= 1'b0;
                    end
`endif
                end
                EVAL: begin
                    if (cell_free_c && (move_count < 4'd9)) begin
                        board[cell_idx_c] <= turn;
                        turn              <= other_c;
                        move_count        <= move_count + 4'd1;
                        err               <= 1'b0;
`ifdef MOVE_CONTROLLER_UNDO_EN
                        rec_idx           <= cell_idx_c;
                        rec_valid         <= 1'b1;
`endif
                    end else begin
                        err <= 1'b1;
                    end
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (win != 2'b00) begin
                        state <= LOCKED;
                    end else if (!place_level) begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
                    state <= LOCKED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pos1 = board[0];
    assign pos2 = board[1];
    assign pos3 = board[2];
    assign pos4 = board[3];
    assign pos5 = board[4];
    assign pos6 = board[5];
    assign pos7 = board[6];
    assign pos8 = board[7];
    assign pos9 = board[8];

endmodule
